// File: rtl/uart_fifo_periph.sv
// ---------------------------------------------------------------------------
// uart_fifo_periph
//
// Memory-mapped UART channel with 16-entry TX and RX FIFOs, a programmable
// baud divisor feeding a 16x oversampling tick, configurable payload width,
// sticky clear-on-read error flags and a maskable level interrupt.
// Everything runs in the sysclk domain.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 TXD    write pushes a byte into the TX FIFO, reads 0
//   0x04 RXD    read pops the RX FIFO head (0 when empty)
//   0x08 CON    tx_en, rx_en, rx_irq_en, tx_irq_en (+ parity_en, parity_odd)
//   0x0C STATUS rx_nempty, rx_full, tx_full, tx_empty, tx_busy,
//               rx_overrun, frame_err, tx_overflow (+ parity_err)
//   0x10 DIV    baud divisor, tick period is DIV+1 sysclk cycles
//
// Ports:
//   sysclk  system clock
//   reset   synchronous active-high reset
//   rd, wr  bus read / write strobes
//   addr    bus byte address
//   wdata   bus write data
//   rdata   bus read data (combinational, 0 when rd is low)
//   rxd     serial input, asynchronous, idle high
//   txd     serial output, registered, idle high
//   irqout  registered level interrupt
//
// Optional feature: define UART_PARITY_EN to add a parity bit to both
// directions (CON bit4 parity_en, bit5 parity_odd, STATUS bit8 parity_err).
// ---------------------------------------------------------------------------

// Synchronous FIFO with a head-of-queue output.  A push while full is
// accepted only when a pop happens in the same cycle.
module uart_fifo_periph_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head    = mem[rptr];

   // Storage array is not reset; only the pointers define validity.
   always_ff @(posedge sysclk) begin
      if (push_ok) mem[wptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop_ok)  rptr <= rptr + AW'(1);
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end
endmodule

module uart_fifo_periph #(
   parameter logic [31:0] BASE_ADDR  = 32'h40000018,
   parameter int          DATA_BITS  = 8,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd325
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        rxd,
   output logic        txd,
   output logic        irqout
);
`ifdef UART_PARITY_EN
   localparam int CON_W = 6;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
   localparam int CON_W = 4;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

   logic sel_txd, sel_rxd, sel_con, sel_stat, sel_div;
   logic [CON_W-1:0] con_reg;
   logic [15:0] div_reg, tick_cnt;
   logic tick, tx_en, rx_en, rx_irq_en, tx_irq_en;
   logic tx_push, tx_pop, tx_empty, tx_full, tx_busy;
   logic rx_push_req, rx_pop, rx_empty, rx_full;
   logic [DATA_BITS-1:0] tx_head, rx_head;
   logic rx_overrun, frame_err, tx_overflow, frame_set, stat_read;
   logic [31:0] status_word;
   logic unused_bits;

   tx_state_t tx_state, tx_state_n;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
   logic [3:0] tx_tcnt, tx_tcnt_n;
   logic [2:0] tx_bcnt, tx_bcnt_n;
   logic tx_bit_end, tx_load, txd_n;

   rx_state_t rx_state, rx_state_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
   logic [3:0] rx_tcnt, rx_tcnt_n;
   logic [2:0] rx_bcnt, rx_bcnt_n;
   logic rx_sync1, rx_bit, rx_mid, rx_bit_end;

`ifdef UART_PARITY_EN
   logic parity_en, parity_odd, parity_err, parity_set;
   logic tx_par, tx_par_n, rx_par_bad, rx_par_bad_n;
   assign parity_en  = con_reg[4];
   assign parity_odd = con_reg[5];
`endif

   assign unused_bits = &{1'b0, wdata[31:16]};

   assign sel_txd  = (addr == BASE_ADDR);
   assign sel_rxd  = (addr == BASE_ADDR + 32'h4);
   assign sel_con  = (addr == BASE_ADDR + 32'h8);
   assign sel_stat = (addr == BASE_ADDR + 32'hC);
   assign sel_div  = (addr == BASE_ADDR + 32'h10);

   assign tx_en     = con_reg[0];
   assign rx_en     = con_reg[1];
   assign rx_irq_en = con_reg[2];
   assign tx_irq_en = con_reg[3];

   assign tx_push   = wr & sel_txd;
   assign rx_pop    = rd & sel_rxd;
   assign stat_read = rd & sel_stat;
   assign tx_busy   = (tx_state != TX_IDLE);

   uart_fifo_periph_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .sysclk(sysclk), .reset(reset), .push(tx_push), .pop(tx_pop),
      .wdata(wdata[DATA_BITS-1:0]), .head(tx_head), .empty(tx_empty), .full(tx_full)
   );

   uart_fifo_periph_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .sysclk(sysclk), .reset(reset), .push(rx_push_req), .pop(rx_pop),
      .wdata(rx_shift_n), .head(rx_head), .empty(rx_empty), .full(rx_full)
   );

   // Control and divisor registers.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         con_reg <= '0;
         div_reg <= DIV_RESET;
      end else begin
         if (wr && sel_con) con_reg <= wdata[CON_W-1:0];
         if (wr && sel_div) div_reg <= wdata[15:0];
      end
   end

   // Oversampling tick: counter wraps at DIV, restarting whenever DIV is
   // rewritten so a smaller divisor never leaves the counter above it.
   assign tick = (tick_cnt == div_reg);
   always_ff @(posedge sysclk) begin
      if (reset || (wr && sel_div) || tick) tick_cnt <= '0;
      else                                  tick_cnt <= tick_cnt + 16'd1;
   end

   // TX next-state logic.  A new byte is loaded on a tick either from IDLE
   // or at the end of STOP, so queued bytes go out with no idle gap.
   // txd is registered from the next-state view so it lines up with state.
   assign tx_bit_end = tick & (tx_tcnt == 4'd15);
   assign tx_load = tick & tx_en & ~tx_empty &
                    ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));
   always_comb begin
      tx_state_n = tx_state;
      tx_shift_n = tx_shift;
      tx_bcnt_n  = tx_bcnt;
      tx_tcnt_n  = tick ? tx_tcnt + 4'd1 : tx_tcnt;
      tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_n   = tx_par;
`endif
      case (tx_state)
         TX_IDLE:  tx_tcnt_n = '0;
         TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_n = tx_shift >> 1;
               if (tx_bcnt == 3'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
                  tx_state_n = parity_en ? TX_PARITY : TX_STOP;
`else
                  tx_state_n = TX_STOP;
`endif
               end else begin
                  tx_bcnt_n = tx_bcnt + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
`endif
         TX_STOP:  if (tx_bit_end) tx_state_n = TX_IDLE;
         default:  tx_state_n = TX_IDLE;
      endcase
      if (tx_load) begin
         tx_pop     = 1'b1;
         tx_shift_n = tx_head;
         tx_bcnt_n  = '0;
         tx_tcnt_n  = '0;
         tx_state_n = TX_START;
`ifdef UART_PARITY_EN
         tx_par_n   = (^tx_head) ^ parity_odd;
`endif
      end
      case (tx_state_n)
         TX_START: txd_n = 1'b0;
         TX_DATA:  txd_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
         TX_PARITY: txd_n = tx_par_n;
`endif
         default:  txd_n = 1'b1;
      endcase
   end

   // TX state register.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         txd      <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_state_n;
         tx_shift <= tx_shift_n;
         tx_tcnt  <= tx_tcnt_n;
         tx_bcnt  <= tx_bcnt_n;
         txd      <= txd_n;
`ifdef UART_PARITY_EN
         tx_par   <= tx_par_n;
`endif
      end
   end

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_sync1 <= 1'b1;
         rx_bit   <= 1'b1;
      end else begin
         rx_sync1 <= rxd;
         rx_bit   <= rx_sync1;
      end
   end

   // RX next-state logic.  The START state realigns the tick count to
   // mid-bit, so every later sample falls 16 ticks apart in bit centres.
   // Dropping rx_en forces IDLE and suppresses any push.
   assign rx_mid     = tick & (rx_tcnt == 4'd7);
   assign rx_bit_end = tick & (rx_tcnt == 4'd15);
   always_comb begin
      rx_state_n  = rx_state;
      rx_shift_n  = rx_shift;
      rx_bcnt_n   = rx_bcnt;
      rx_tcnt_n   = tick ? rx_tcnt + 4'd1 : rx_tcnt;
      rx_push_req = 1'b0;
      frame_set   = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_n = rx_par_bad;
      parity_set   = 1'b0;
`endif
      if (!rx_en) begin
         rx_state_n = RX_IDLE;
         rx_tcnt_n  = '0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               rx_tcnt_n = '0;
               if (!rx_bit) begin
                  rx_state_n = RX_START;
                  rx_bcnt_n  = '0;
`ifdef UART_PARITY_EN
                  rx_par_bad_n = 1'b0;
`endif
               end
            end
            RX_START: begin
               if (rx_mid) begin
                  rx_tcnt_n  = '0;
                  rx_state_n = rx_bit ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (rx_bit_end) begin
                  rx_shift_n = {rx_bit, rx_shift[DATA_BITS-1:1]};
                  if (rx_bcnt == 3'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
                     rx_state_n = parity_en ? RX_PARITY : RX_STOP;
`else
                     rx_state_n = RX_STOP;
`endif
                  end else begin
                     rx_bcnt_n = rx_bcnt + 3'd1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
               if (rx_bit_end) begin
                  rx_par_bad_n = rx_bit ^ (^rx_shift) ^ parity_odd;
                  rx_state_n   = RX_STOP;
               end
            end
`endif
            RX_STOP: begin
               if (rx_bit_end) begin
                  rx_state_n = RX_IDLE;
                  if (rx_bit) begin
`ifdef UART_PARITY_EN
                     if (rx_par_bad) parity_set  = 1'b1;
                     else            rx_push_req = 1'b1;
`else
                     rx_push_req = 1'b1;
`endif
                  end else begin
                     frame_set = 1'b1;
                  end
               end
            end
            default: rx_state_n = RX_IDLE;
         endcase
      end
   end

   // RX state register.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_shift <= '0;
         rx_tcnt  <= '0;
         rx_bcnt  <= '0;
`ifdef UART_PARITY_EN
         rx_par_bad <= 1'b0;
`endif
      end else begin
         rx_state <= rx_state_n;
         rx_shift <= rx_shift_n;
         rx_tcnt  <= rx_tcnt_n;
         rx_bcnt  <= rx_bcnt_n;
`ifdef UART_PARITY_EN
         rx_par_bad <= rx_par_bad_n;
`endif
      end
   end

   // Sticky error flags: a set event outranks the clear-on-read.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_overrun  <= 1'b0;
         frame_err   <= 1'b0;
         tx_overflow <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         rx_overrun  <= (rx_push_req & rx_full & ~(rx_pop & ~rx_empty)) | (rx_overrun & ~stat_read);
         frame_err   <= frame_set | (frame_err & ~stat_read);
         tx_overflow <= (tx_push & tx_full & ~tx_pop) | (tx_overflow & ~stat_read);
`ifdef UART_PARITY_EN
         parity_err  <= parity_set | (parity_err & ~stat_read);
`endif
      end
   end

   // Interrupt is registered, so it trails its cause by one cycle.
   always_ff @(posedge sysclk) begin
      if (reset) irqout <= 1'b0;
      else       irqout <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_busy);
   end

`ifdef UART_PARITY_EN
   assign status_word = {23'd0, parity_err, tx_overflow, frame_err, rx_overrun,
                         tx_busy, tx_empty, tx_full, rx_full, ~rx_empty};
`else
   assign status_word = {24'd0, tx_overflow, frame_err, rx_overrun,
                         tx_busy, tx_empty, tx_full, rx_full, ~rx_empty};
`endif

   // Combinational read mux; TXD and unmapped addresses read as zero.
   always_comb begin
      rdata = '0;
      if (rd) begin
         if (sel_rxd && !rx_empty) rdata = 32'(rx_head);
         if (sel_con)              rdata = 32'(con_reg);
         if (sel_stat)             rdata = status_word;
         if (sel_div)              rdata = {16'd0, div_reg};
      end
   end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_periph
//
// Directed bench for uart_fifo_periph with DIV=3 (4-cycle tick, 64-cycle
// bit).  Drives the bus and rxd on falling clock edges and samples outputs
// there too, checking against hand-computed register and waveform values.
// ---------------------------------------------------------------------------
module tb_uart_fifo_periph;
   localparam logic [31:0] BASE     = 32'h40000018;
   localparam logic [31:0] OFF_TXD  = 32'h0;
   localparam logic [31:0] OFF_RXD  = 32'h4;
   localparam logic [31:0] OFF_CON  = 32'h8;
   localparam logic [31:0] OFF_STAT = 32'hC;
   localparam logic [31:0] OFF_DIV  = 32'h10;

   logic        sysclk;
   logic        reset;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rxd;
   logic        txd;
   logic        irqout;

   int          tests_run;
   int          fail_count;
   logic [31:0] rv;
   logic [7:0]  got;
   logic [7:0]  exp_byte;
   logic        seen;

   uart_fifo_periph dut (
      .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(rdata), .rxd(rxd), .txd(txd), .irqout(irqout)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // One bus access spanning one clock; reads sample rdata mid-cycle.
   task automatic applyStimulus(input logic is_write, input logic [31:0] off,
                                input logic [31:0] data, output logic [31:0] result);
      @(negedge sysclk);
      addr   = BASE + off;
      result = '0;
      if (is_write) begin
         wr    = 1'b1;
         wdata = data;
      end else begin
         rd = 1'b1;
         #1 result = rdata;
      end
      @(negedge sysclk);
      wr    = 1'b0;
      rd    = 1'b0;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitTxFall(output logic found);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge sysclk);
         if (txd === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic stop_bit);
      rxd = 1'b0;
      repeat (64) @(negedge sysclk);
      for (int b = 0; b < 8; b++) begin
         rxd = data[b];
         repeat (64) @(negedge sysclk);
      end
      rxd = stop_bit;
      repeat (64) @(negedge sysclk);
      rxd = 1'b1;
   endtask

   initial begin
      tests_run  = 0;
      fail_count = 0;
      reset = 1'b1;
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
      rxd   = 1'b1;
      repeat (3) @(negedge sysclk);
      reset = 1'b0;

      // Reset state
      checkOutput("reset_txd", txd, 1);
      checkOutput("reset_irq", irqout, 0);
      applyStimulus(0, OFF_TXD, 0, rv);  checkOutput("reset_TXD", rv, 0);
      applyStimulus(0, OFF_RXD, 0, rv);  checkOutput("reset_RXD", rv, 0);
      applyStimulus(0, OFF_CON, 0, rv);  checkOutput("reset_CON", rv, 0);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("reset_STATUS", rv, 32'h08);
      applyStimulus(0, OFF_DIV, 0, rv);  checkOutput("reset_DIV", rv, 325);

      // Single TX frame 0xA5
      applyStimulus(1, OFF_DIV, 3, rv);
      applyStimulus(0, OFF_DIV, 0, rv);  checkOutput("div_readback", rv, 3);
      applyStimulus(1, OFF_CON, 1, rv);
      applyStimulus(1, OFF_TXD, 32'hA5, rv);
      waitTxFall(seen);
      checkOutput("tx_a5_start_seen", seen, 1);
      exp_byte = 8'hA5;
      repeat (32) @(negedge sysclk);
      checkOutput("tx_a5_start_bit", txd, 0);
      for (int b = 0; b < 8; b++) begin
         repeat (64) @(negedge sysclk);
         checkOutput($sformatf("tx_a5_bit%0d", b), txd, exp_byte[b]);
      end
      repeat (64) @(negedge sysclk);
      checkOutput("tx_a5_stop_bit", txd, 1);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("tx_busy_in_stop", rv, 32'h18);
      repeat (40) @(negedge sysclk);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("tx_idle_after", rv, 32'h08);

      // TX overflow with tx_en off, then 16 back-to-back frames
      applyStimulus(1, OFF_CON, 0, rv);
      for (int i = 0; i < 17; i++) applyStimulus(1, OFF_TXD, 32'h80 + i, rv);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("tx_full_overflow", rv, 32'h84);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("tx_overflow_cleared", rv, 32'h04);
      applyStimulus(1, OFF_CON, 1, rv);
      waitTxFall(seen);
      checkOutput("tx_burst_start_seen", seen, 1);
      for (int f = 0; f < 16; f++) begin
         repeat (32) @(negedge sysclk);
         checkOutput($sformatf("tx_burst%0d_start", f), txd, 0);
         for (int b = 0; b < 8; b++) begin
            repeat (64) @(negedge sysclk);
            got[b] = txd;
         end
         checkOutput($sformatf("tx_burst%0d_data", f), got, 32'h80 + f);
         repeat (64) @(negedge sysclk);
         checkOutput($sformatf("tx_burst%0d_stop", f), txd, 1);
         repeat (32) @(negedge sysclk);
      end
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("tx_burst_done", rv, 32'h08);

      // RX single frame with interrupt
      applyStimulus(1, OFF_CON, 32'h6, rv);
      checkOutput("irq_idle_low", irqout, 0);
      sendFrame(8'h3C, 1'b1);
      checkOutput("irq_after_rx", irqout, 1);
      applyStimulus(0, OFF_RXD, 0, rv);  checkOutput("rx_3c", rv, 32'h3C);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_empty_after_pop", rv, 32'h08);
      checkOutput("irq_dropped", irqout, 0);

      // RX overrun: 17 frames without reading
      for (int f = 0; f < 17; f++) sendFrame(8'h40 + 8'(f), 1'b1);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_overrun_status", rv, 32'h2B);
      for (int f = 0; f < 16; f++) begin
         applyStimulus(0, OFF_RXD, 0, rv);
         checkOutput($sformatf("rx_fifo%0d", f), rv, 32'h40 + f);
      end
      applyStimulus(0, OFF_RXD, 0, rv);  checkOutput("rx_empty_read", rv, 0);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_overrun_cleared", rv, 32'h08);

      // One-tick glitch is a false start
      rxd = 1'b0;
      repeat (4) @(negedge sysclk);
      rxd = 1'b1;
      repeat (200) @(negedge sysclk);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_glitch_no_push", rv, 32'h08);

      // Stop bit driven low gives frame error and no push
      sendFrame(8'h99, 1'b0);
      repeat (100) @(negedge sysclk);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_frame_err", rv, 32'h48);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_frame_err_cleared", rv, 32'h08);

      // rx_en cleared mid-frame drops the partial byte
      rxd = 1'b0;
      repeat (256) @(negedge sysclk);
      applyStimulus(1, OFF_CON, 0, rv);
      rxd = 1'b1;
      repeat (700) @(negedge sysclk);
      applyStimulus(1, OFF_CON, 32'h6, rv);
      sendFrame(8'h55, 1'b1);
      repeat (20) @(negedge sysclk);
      applyStimulus(0, OFF_STAT, 0, rv); checkOutput("rx_abort_one_entry", rv, 32'h09);
      applyStimulus(0, OFF_RXD, 0, rv);  checkOutput("rx_abort_55", rv, 32'h55);
      applyStimulus(0, OFF_RXD, 0, rv);  checkOutput("rx_abort_empty", rv, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end
endmodule
